// File: rtl/vec_reg_bank_if.sv
// ----------------------------------------------------------------------------
// vec_reg_bank_if
//   Bundle between decode/writeback (master) and the vector register bank
//   (slave).
//
//   master drives : we3, wa3, wd3, wev, bcast, ra1, ra2
//   slave drives  : rd1, rd2, ready
//
//   Vector data is packed with lane i at bits [i*LANE_W +: LANE_W].
// ----------------------------------------------------------------------------
interface vec_reg_bank_if #(
    parameter int NREG   = 16,
    parameter int LANES  = 4,
    parameter int LANE_W = 32
);
    localparam int AW = $clog2(NREG);

    logic                    we3;
    logic [AW-1:0]           wa3;
    logic [LANES*LANE_W-1:0] wd3;
    logic [LANES-1:0]        wev;
    logic                    bcast;
    logic [AW-1:0]           ra1;
    logic [AW-1:0]           ra2;
    logic [LANES*LANE_W-1:0] rd1;
    logic [LANES*LANE_W-1:0] rd2;
    logic                    ready;

    modport master (
        output we3, wa3, wd3, wev, bcast, ra1, ra2,
        input  rd1, rd2, ready
    );

    modport slave (
        input  we3, wa3, wd3, wev, bcast, ra1, ra2,
        output rd1, rd2, ready
    );
endinterface

// File: rtl/vec_reg_bank.sv
// ----------------------------------------------------------------------------
// vec_reg_bank
//   NREG x LANES x LANE_W vector register file: two combinational read ports,
//   one write port with per-lane mask, lane-0 broadcast and same-cycle
//   write-to-read bypass. Storage has no reset; a clear engine zeroes one
//   register per cycle after reset and raises ready when finished.
//
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous reset, active high (restarts the clear)
//     bus  : vec_reg_bank_if.slave (write port, read addresses, rd1/rd2, ready)
//
// vrb_lane
//   One lane column of the bank: NREG x LANE_W storage, its write/clear port
//   and the lane's slice of both read ports, including bypass.
// ----------------------------------------------------------------------------
module vrb_lane #(
    parameter int NREG   = 16,
    parameter int LANE_W = 32,
    parameter int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              i_clr_en,   // zero register i_clr_addr this edge
    input  logic [AW-1:0]     i_clr_addr,
    input  logic              i_ready,    // bank in RUN: reads/bypass live
    input  logic              i_wr_gate,  // writes may commit this edge
    input  logic              i_we3,
    input  logic              i_wev,      // this lane's mask bit
    input  logic [AW-1:0]     i_wa,
    input  logic [LANE_W-1:0] i_wd,       // lane data after broadcast select
    input  logic [AW-1:0]     i_ra1,
    input  logic [AW-1:0]     i_ra2,
    output logic [LANE_W-1:0] o_rd1,
    output logic [LANE_W-1:0] o_rd2
);
    logic [LANE_W-1:0] r_mem [NREG];
    logic              w_hit;

    assign w_hit = i_we3 & i_wev;

    // No reset on storage so it can map to RAM; the clear engine owns init.
    always_ff @(posedge clk) begin
        if (i_clr_en)
            r_mem[i_clr_addr] <= '0;
        else if (i_wr_gate && w_hit)
            r_mem[i_wa] <= i_wd;
    end

    // Uninitialised storage is masked to zero until the clear completes.
    always_comb begin
        o_rd1 = '0;
        o_rd2 = '0;
        if (i_ready) begin
            o_rd1 = (w_hit && (i_ra1 == i_wa)) ? i_wd : r_mem[i_ra1];
            o_rd2 = (w_hit && (i_ra2 == i_wa)) ? i_wd : r_mem[i_ra2];
        end
    end
endmodule

module vec_reg_bank #(
    parameter int NREG   = 16,
    parameter int LANES  = 4,
    parameter int LANE_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    vec_reg_bank_if.slave bus
);
    localparam int AW = $clog2(NREG);

    typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_clr_ptr, w_clr_ptr_nxt;
    logic          w_ready, w_clr_en, w_wr_gate;

    logic [LANES-1:0][LANE_W-1:0] w_wd, w_wd_lane, w_rd1, w_rd2;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        case (r_state)
            S_CLEAR: begin
                if (r_clr_ptr == AW'(NREG - 1))
                    w_state_nxt = S_RUN;
                else
                    w_clr_ptr_nxt = r_clr_ptr + 1'b1;
            end
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // rst is qualified in so an edge that samples reset neither clears nor
    // writes; the clear then restarts cleanly from register 0.
    always_comb begin
        w_ready   = (r_state == S_RUN);
        w_clr_en  = (r_state == S_CLEAR) && !rst;
        w_wr_gate = (r_state == S_RUN)   && !rst;
    end

    // ---------------- datapath ----------------
    assign w_wd = bus.wd3;

    // Broadcast replicates lane 0; the mask still selects which lanes land.
    always_comb begin
        for (int i = 0; i < LANES; i++)
            w_wd_lane[i] = bus.bcast ? w_wd[0] : w_wd[i];
    end

    vrb_lane #(
        .NREG   (NREG),
        .LANE_W (LANE_W),
        .AW     (AW)
    ) u_lane [LANES-1:0] (
        .clk        (clk),
        .i_clr_en   (w_clr_en),
        .i_clr_addr (r_clr_ptr),
        .i_ready    (w_ready),
        .i_wr_gate  (w_wr_gate),
        .i_we3      (bus.we3),
        .i_wev      (bus.wev),
        .i_wa       (bus.wa3),
        .i_wd       (w_wd_lane),
        .i_ra1      (bus.ra1),
        .i_ra2      (bus.ra2),
        .o_rd1      (w_rd1),
        .o_rd2      (w_rd2)
    );

    assign bus.rd1   = w_rd1;
    assign bus.rd2   = w_rd2;
    assign bus.ready = w_ready;
endmodule

// File: tb/tb_vec_reg_bank.sv
module tb_vec_reg_bank;
    localparam int NREG   = 16;
    localparam int LANES  = 4;
    localparam int LANE_W = 32;
    localparam int W      = LANES * LANE_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vec_reg_bank_if #(.NREG(NREG), .LANES(LANES), .LANE_W(LANE_W)) vif();

    vec_reg_bank #(.NREG(NREG), .LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    typedef struct packed {
        logic         rdy;
        logic [W-1:0] r1;
        logic [W-1:0] r2;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;

    // Reference model: whole-vector view of the register file.
    logic [W-1:0] m_mem [NREG];
    logic         m_ready = 1'b0;
    int           m_cnt   = 0;

    function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] wd,
                                           input logic [LANES-1:0] wev, input logic bc);
        logic [W-1:0] v;
        v = old;
        for (int i = 0; i < LANES; i++)
            if (wev[i]) v[i*LANE_W +: LANE_W] = bc ? wd[LANE_W-1:0] : wd[i*LANE_W +: LANE_W];
        return v;
    endfunction

    function automatic logic [W-1:0] model_rd(input logic [3:0] ra);
        logic [W-1:0] v;
        if (!m_ready) return '0;
        v = m_mem[ra];
        if (vif.we3 && ra == vif.wa3) v = merge(v, vif.wd3, vif.wev, vif.bcast);
        return v;
    endfunction

    // One clock of stimulus: drive at negedge, push expectation, advance model.
    task automatic cyc(input logic r, input logic we, input logic [3:0] wa,
                       input logic [W-1:0] wd, input logic [3:0] wev, input logic bc,
                       input logic [3:0] ra1, input logic [3:0] ra2);
        exp_t e;
        @(negedge clk);
        rst = r; vif.we3 = we; vif.wa3 = wa; vif.wd3 = wd; vif.wev = wev;
        vif.bcast = bc; vif.ra1 = ra1; vif.ra2 = ra2;
        e.rdy = m_ready;
        e.r1  = model_rd(ra1);
        e.r2  = model_rd(ra2);
        q.push_back(e);
        @(posedge clk);
        if (r) begin
            m_ready = 1'b0;
            m_cnt   = 0;
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == NREG) begin
                for (int k = 0; k < NREG; k++) m_mem[k] = '0;
                m_ready = 1'b1;
            end
        end else if (we) begin
            m_mem[wa] = merge(m_mem[wa], wd, wev, bc);
        end
    endtask

    task automatic idle(input int n, input logic [3:0] ra1, input logic [3:0] ra2);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 4'h0, '0, 4'h0, 1'b0, ra1, ra2);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                cyc_no++;
                checks++;
                if (vif.ready !== e.rdy) begin
                    errors++;
                    $display("FAIL ready cyc=%0d got=%b exp=%b", cyc_no, vif.ready, e.rdy);
                end
                checks++;
                if (vif.rd1 !== e.r1) begin
                    errors++;
                    $display("FAIL rd1 cyc=%0d got=%h exp=%h", cyc_no, vif.rd1, e.r1);
                end
                checks++;
                if (vif.rd2 !== e.r2) begin
                    errors++;
                    $display("FAIL rd2 cyc=%0d got=%h exp=%h", cyc_no, vif.rd2, e.r2);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]   wa, r1, r2;
        logic [W-1:0] wd;
        vif.we3 = 1'b0; vif.wa3 = '0; vif.wd3 = '0; vif.wev = '0;
        vif.bcast = 1'b0; vif.ra1 = '0; vif.ra2 = '0;

        // Reset and clear: ready must rise exactly after the 16th released edge.
        cyc(1'b1, 1'b0, 4'h0, '0, 4'h0, 1'b0, 4'h5, 4'h5);
        cyc(1'b1, 1'b0, 4'h0, '0, 4'h0, 1'b0, 4'h5, 4'h5);
        idle(NREG + 1, 4'h5, 4'h5);
        for (int k = 0; k < NREG; k++) idle(1, 4'(k), 4'(NREG - 1 - k));

        // Full write with bypass, then read back from storage.
        cyc(1'b0, 1'b1, 4'h0, W'(128'hFF), 4'hF, 1'b0, 4'h0, 4'h0);
        idle(1, 4'h0, 4'h0);

        // Masked write to register F.
        cyc(1'b0, 1'b1, 4'hF, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, 4'b1001, 1'b0, 4'hF, 4'h0);
        idle(1, 4'hF, 4'hF);

        // Broadcast lane 0 into lanes 1 and 2 of register 3.
        cyc(1'b0, 1'b1, 4'h3, W'(128'h12345678), 4'b0110, 1'b1, 4'h3, 4'h3);
        idle(1, 4'h3, 4'hF);

        // Legal no-op: we3 with an empty mask.
        cyc(1'b0, 1'b1, 4'h3, {W{1'b1}}, 4'b0000, 1'b0, 4'h3, 4'h3);
        idle(1, 4'h3, 4'h3);

        // Write during clear is ignored; ready timing unchanged.
        cyc(1'b1, 1'b0, 4'h0, '0, 4'h0, 1'b0, 4'h2, 4'h2);
        idle(2, 4'h2, 4'h2);
        cyc(1'b0, 1'b1, 4'h2, W'(128'h1), 4'hF, 1'b0, 4'h2, 4'h2);
        idle(NREG - 2, 4'h2, 4'h2);
        idle(2, 4'h2, 4'h2);

        // Reset mid-operation.
        cyc(1'b0, 1'b1, 4'h0, {4{32'hCAFEF00D}}, 4'hF, 1'b0, 4'h0, 4'hF);
        cyc(1'b0, 1'b1, 4'hF, {4{32'h5A5A1234}}, 4'hF, 1'b0, 4'h0, 4'hF);
        cyc(1'b1, 1'b0, 4'h0, '0, 4'h0, 1'b0, 4'h0, 4'hF);
        idle(NREG + 2, 4'h0, 4'hF);

        // Randomized traffic with biased address collisions and rare resets.
        for (int n = 0; n < 400; n++) begin
            wa = 4'($urandom_range(0, NREG - 1));
            wd = {$urandom, $urandom, $urandom, $urandom};
            r1 = ($urandom_range(0, 1) == 0) ? wa : 4'($urandom_range(0, NREG - 1));
            r2 = ($urandom_range(0, 1) == 0) ? wa : 4'($urandom_range(0, NREG - 1));
            cyc(($urandom_range(0, 127) == 0), 1'($urandom_range(0, 3) != 0), wa, wd,
                4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), r1, r2);
        end
        idle(2, 4'h0, 4'h1);

        repeat (3) @(negedge clk);
        #5;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
